// File: rtl/alu_core.sv
// alu_core: RV32I execute-stage ALU with a one-cycle registered result.
// Define ALU_MEXT_EN to build the single-cycle RV32M multiply/divide datapath.
module alu_core (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [4:0]  alu_control,
   output logic [31:0] result
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned SHW   = 5;

   typedef enum logic [4:0] {
      OP_ADD    = 5'b00000,
      OP_SUB    = 5'b00001,
      OP_OR     = 5'b00010,
      OP_XOR    = 5'b00011,
      OP_AND    = 5'b00100,
      OP_SLL    = 5'b00101,
      OP_SRL    = 5'b00110,
      OP_SRA    = 5'b00111,
      OP_MUL    = 5'b01000,
      OP_MULH   = 5'b01001,
      OP_MULHSU = 5'b01010,
      OP_MULHU  = 5'b01011,
      OP_DIV    = 5'b01100,
      OP_DIVU   = 5'b01101,
      OP_REM    = 5'b01110,
      OP_REMU   = 5'b01111,
      OP_SLT    = 5'b10000,
      OP_SLTU   = 5'b10001,
      OP_PASSB  = 5'b10010
   } alu_op_e;

   alu_op_e          op;
   logic [SHW-1:0]   shamt;
   logic [XLEN-1:0]  result_c;

   assign op    = alu_op_e'(alu_control);
   assign shamt = data2[SHW-1:0];

`ifdef ALU_MEXT_EN
   logic              a_sext;
   logic              b_sext;
   logic [2*XLEN-1:0] mul_a;
   logic [2*XLEN-1:0] mul_b;
   logic [2*XLEN-1:0] product;
   logic              div_signed;
   logic              a_neg;
   logic              b_neg;
   logic              div_by_zero;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic [XLEN-1:0]   div_den;
   logic [XLEN-1:0]   quo_mag;
   logic [XLEN-1:0]   rem_mag;
   logic [XLEN-1:0]   quotient;
   logic [XLEN-1:0]   remainder;

   // One shared 64-bit multiplier; operand extension selects the signedness.
   always_comb begin
      a_sext  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU);
      b_sext  = (op == OP_MUL) || (op == OP_MULH);
      mul_a   = {{XLEN{a_sext & data1[XLEN-1]}}, data1};
      mul_b   = {{XLEN{b_sext & data2[XLEN-1]}}, data2};
      product = mul_a * mul_b;
   end

   // Sign-magnitude divider; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   always_comb begin
      div_signed  = (op == OP_DIV) || (op == OP_REM);
      a_neg       = div_signed & data1[XLEN-1];
      b_neg       = div_signed & data2[XLEN-1];
      a_mag       = a_neg ? (XLEN'(0) - data1) : data1;
      b_mag       = b_neg ? (XLEN'(0) - data2) : data2;
      div_by_zero = (data2 == '0);
      div_den     = div_by_zero ? XLEN'(1) : b_mag;
      quo_mag     = a_mag / div_den;
      rem_mag     = a_mag % div_den;
      quotient    = (a_neg ^ b_neg) ? (XLEN'(0) - quo_mag) : quo_mag;
      remainder   = a_neg ? (XLEN'(0) - rem_mag) : rem_mag;
      if (div_by_zero) begin
         quotient  = '1;
         remainder = data1;
      end
   end
`endif

   // Next-result selection.
   always_comb begin
      result_c = '0;
      case (op)
         OP_ADD:    result_c = data1 + data2;
         OP_SUB:    result_c = data1 - data2;
         OP_OR:     result_c = data1 | data2;
         OP_XOR:    result_c = data1 ^ data2;
         OP_AND:    result_c = data1 & data2;
         OP_SLL:    result_c = data1 << shamt;
         OP_SRL:    result_c = data1 >> shamt;
         OP_SRA:    result_c = $signed(data1) >>> shamt;
`ifdef ALU_MEXT_EN
         OP_MUL:    result_c = product[XLEN-1:0];
         OP_MULH:   result_c = product[2*XLEN-1:XLEN];
         OP_MULHSU: result_c = product[2*XLEN-1:XLEN];
         OP_MULHU:  result_c = product[2*XLEN-1:XLEN];
         OP_DIV:    result_c = quotient;
         OP_DIVU:   result_c = quotient;
         OP_REM:    result_c = remainder;
         OP_REMU:   result_c = remainder;
`endif
         OP_SLT:    result_c = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(data2))};
         OP_SLTU:   result_c = {{(XLEN-1){1'b0}}, (data1 < data2)};
         OP_PASSB:  result_c = data2;
         default:   result_c = '0;
      endcase
   end

   // Result register; reset clears it immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result <= '0;
      end else begin
         result <= result_c;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed literal cases plus randomized
// operations compared every cycle against a behavioural model.
module tb_alu_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [4:0]  alu_control;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q;

   alu_core dut (
      .clk         (clk),
      .reset       (reset),
      .data1       (data1),
      .data2       (data2),
      .alu_control (alu_control),
      .result      (result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      ps;
      logic [63:0] pu;
      int          sa;
      int          sb;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a | b;
         5'd3:  return a ^ b;
         5'd4:  return a & b;
         5'd5:  return a << b[4:0];
         5'd6:  return a >> b[4:0];
         5'd7:  return sa >>> b[4:0];
`ifdef ALU_MEXT_EN
         5'd8:  begin ps = longint'(sa) * longint'(sb); return ps[31:0]; end
         5'd9:  begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
         5'd10: begin ps = longint'(sa) * longint'({32'd0, b}); return ps[63:32]; end
         5'd11: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
         5'd12: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         5'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd14: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
         end
         5'd15: return (b == 0) ? a : a % b;
`endif
         5'd16: return (sa < sb) ? 32'd1 : 32'd0;
         5'd17: return (a < b) ? 32'd1 : 32'd0;
         5'd18: return b;
         default: return 32'd0;
      endcase
   endfunction

   // Expected output: cleared by reset at once, otherwise model of last edge's inputs.
   always @(posedge clk or posedge reset) begin
      if (reset) exp_q <= 32'd0;
      else       exp_q <= model(alu_control, data1, data2);
   end

   // Continuous compare on the falling edge.
   always @(negedge clk) begin
      checks++;
      if (result !== exp_q) begin
         errors++;
         $display("FAIL cycle_compare t=%0t op=%b a=%h b=%h got=%h want=%h",
                  $time, alu_control, data1, data2, result, exp_q);
      end
   end

   task automatic check(input string name, input logic [31:0] want);
      checks++;
      if (result !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, result, want);
      end
   endtask

   task automatic apply(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want);
      alu_control = op;
      data1       = a;
      data2       = b;
      @(posedge clk);
      #1;
      check(name, want);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 31));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset       = 1'b1;
      data1       = 32'd0;
      data2       = 32'd0;
      alu_control = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 32'd0);
      reset = 1'b0;

      apply("add", 5'b00000, 32'd10, 32'd5, 32'd15);
      #2 reset = 1'b1;
      #1 check("async_reset", 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1 check("reload_after_reset", 32'd15);

      apply("sub",  5'b00001, 32'd10, 32'd5, 32'd5);
      apply("or",   5'b00010, 32'h0F0F, 32'h00FF, 32'h0000_0FFF);
      apply("xor",  5'b00011, 32'h0F0F, 32'h00FF, 32'h0000_0FF0);
      apply("and",  5'b00100, 32'h0F0F, 32'h00FF, 32'h0000_000F);
      apply("slt_pos",  5'b10000, 32'd5, 32'd10, 32'd1);
      apply("slt_neg",  5'b10000, 32'hFFFF_FFFF, 32'd1, 32'd1);
      apply("sltu_big", 5'b10001, 32'hFFFF_FFFF, 32'd1, 32'd0);
      apply("sll", 5'b00101, 32'h8000_0000, 32'h24, 32'd0);
      apply("srl", 5'b00110, 32'h8000_0000, 32'h24, 32'h0800_0000);
      apply("sra", 5'b00111, 32'h8000_0000, 32'h24, 32'hF800_0000);
      apply("passb", 5'b10010, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000);
      apply("unused_code", 5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
`ifdef ALU_MEXT_EN
      apply("mul",        5'b01000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
      apply("mulhu",      5'b01011, 32'hFFFF_FFFF, 32'd2, 32'd1);
      apply("div_zero",   5'b01100, 32'd7, 32'd0, 32'hFFFF_FFFF);
      apply("rem_zero",   5'b01110, 32'd7, 32'd0, 32'd7);
      apply("div_ovf",    5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      apply("rem_ovf",    5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      apply("div_neg",    5'b01100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      apply("rem_neg",    5'b01110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
`else
      apply("mul_disabled", 5'b01000, 32'hFFFF_FFFF, 32'd2, 32'd0);
      apply("div_disabled", 5'b01100, 32'd7, 32'd0, 32'd0);
`endif

      // Randomized traffic with an occasional mid-cycle reset pulse.
      for (int i = 0; i < 3000; i++) begin
         alu_control = 5'($urandom_range(0, 31));
         data1       = rnd_operand();
         data2       = rnd_operand();
         if (i % 600 == 599) begin
            #2 reset = 1'b1;
            #1 reset = 1'b0;
         end
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
